// File: rtl/lcg_pkg.sv
// -----------------------------------------------------------------------------
// lcg_pkg
// Shared definitions for the Park-Miller LCG (X(n+1) = 16807*X(n) mod 2^31-1):
//   LCG_MOD          - modulus 2^31-1
//   LCG_MULT_DEFAULT - default multiplier 16807
//   lcg_state_t      - checker FSM states
//   lcg_legal()      - a state word is legal when 1 <= word <= LCG_MOD-1
// -----------------------------------------------------------------------------
package lcg_pkg;

   localparam logic [31:0] LCG_MOD          = 32'h7FFF_FFFF;
   localparam int          LCG_MULT_DEFAULT = 16807;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_RED  = 2'd2,
      S_WAIT = 2'd3
   } lcg_state_t;

   // Zero is a fixed point of the recurrence and LCG_MOD aliases zero, so
   // neither can appear in a healthy stream.
   function automatic logic lcg_legal(input logic [31:0] word);
      return (word != 32'd0) && (word < LCG_MOD);
   endfunction

endpackage

// File: rtl/lcg_stream_checker_if.sv
// -----------------------------------------------------------------------------
// lcg_stream_checker_if
// Valid/ready word stream carrying 32-bit LCG states.
//   valid - word valid (from sender)
//   ready - receiver can accept; a transfer occurs when valid && ready
//   data  - LCG state word
// Modports: master (sender), slave (checker).
// -----------------------------------------------------------------------------
interface lcg_stream_checker_if;

   logic        valid;
   logic        ready;
   logic [31:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/lcg_modmul.sv
// -----------------------------------------------------------------------------
// lcg_modmul
// Two-stage registered y = x*MULT mod (2^31-1).
//   Stage 1: product = x*MULT (46-bit unsigned).
//   Stage 2: fold the upper bits back in (2^31 == 1 mod M) and apply a
//            single conditional subtract.
// Result appears two clocks after i_x is presented and stays stable while
// i_x is held. MULT must be below 2^15 so the fold fits in one subtract.
// Ports:
//   i_clk - clock
//   i_rst - asynchronous active-high reset (clears both stages)
//   i_x   - operand, expected in 1..M-1
//   o_y   - registered result
// -----------------------------------------------------------------------------
module lcg_modmul
   import lcg_pkg::*;
#(
   parameter int MULT = LCG_MULT_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [30:0] i_x,
   output logic [30:0] o_y
);

   localparam logic [14:0] MULT_V = 15'(MULT);

   logic [45:0] product_reg;
   logic [31:0] fold;
   logic [31:0] fold_red;
   logic [30:0] y_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         product_reg <= '0;
      end else begin
         product_reg <= 46'(i_x) * 46'(MULT_V);
      end
   end

   // fold < 2*M for any 46-bit product with MULT < 2^15, so one subtract
   // brings it into range.
   assign fold     = {1'b0, product_reg[30:0]} + {17'd0, product_reg[45:31]};
   assign fold_red = (fold >= LCG_MOD) ? (fold - LCG_MOD) : fold;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         y_reg <= '0;
      end else begin
         y_reg <= fold_red[30:0];
      end
   end

   assign o_y = y_reg;

endmodule

// File: rtl/lcg_stream_checker.sv
// -----------------------------------------------------------------------------
// lcg_stream_checker
// Checks a stream of LCG states against X(n+1) = MULT*X(n) mod (2^31-1).
// The first legal word seeds the checker; every later word is compared with
// the prediction from the previously received word (resync on every word).
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_clear          - synchronous soft clear (counters, lock, FSM)
//   s_in             - word stream (slave modport)
//   o_match / o_err  - one-cycle pulses the cycle after each transfer
//   o_locked         - LOCK_N consecutive matches since last error/clear
//   o_match_cnt      - saturating match counter
//   o_err_cnt        - saturating error counter
//   o_last_nibble    - data[3:0] of last accepted word
//   o_err_sticky     - only with LCG_CHK_STICKY_ERR_EN: set by any error,
//                      cleared by i_rst or i_clear
// Optional build macro: LCG_CHK_STICKY_ERR_EN
// -----------------------------------------------------------------------------
module lcg_stream_checker
   import lcg_pkg::*;
#(
   parameter int MULT   = LCG_MULT_DEFAULT,
   parameter int LOCK_N = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear,
   lcg_stream_checker_if.slave  s_in,
   output logic                 o_match,
   output logic                 o_err,
   output logic                 o_locked,
   output logic [CNT_W-1:0]     o_match_cnt,
   output logic [CNT_W-1:0]     o_err_cnt,
   output logic [3:0]           o_last_nibble
`ifdef LCG_CHK_STICKY_ERR_EN
   ,
   output logic                 o_err_sticky
`endif
);

   localparam logic [4:0] LOCK_V = 5'(LOCK_N);

   lcg_state_t       state_reg, state_next;
   logic [30:0]      prev_reg, prev_next;
   logic [3:0]       consec_reg, consec_next;
   logic             match_reg, match_next;
   logic             err_reg, err_next;
   logic             locked_reg, locked_next;
   logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
   logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
   logic [3:0]       nibble_reg, nibble_next;

   logic [30:0]      expected;
   logic             ready;
   logic             xfer;
   logic             word_legal;
   logic [4:0]       consec_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // prev_reg is held from the accept until the next accept, so the
   // free-running pipeline output is valid by the time S_WAIT is reached.
   lcg_modmul #(
      .MULT (MULT)
   ) u_modmul (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_x   (prev_reg),
      .o_y   (expected)
   );

   assign ready      = (state_reg == S_IDLE) || (state_reg == S_WAIT);
   assign s_in.ready = ready;
   assign xfer       = s_in.valid && ready;
   assign word_legal = lcg_legal(s_in.data);
   assign consec_inc = {1'b0, consec_reg} + 5'd1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg     <= S_IDLE;
         prev_reg      <= '0;
         consec_reg    <= '0;
         match_reg     <= 1'b0;
         err_reg       <= 1'b0;
         locked_reg    <= 1'b0;
         match_cnt_reg <= '0;
         err_cnt_reg   <= '0;
         nibble_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         prev_reg      <= prev_next;
         consec_reg    <= consec_next;
         match_reg     <= match_next;
         err_reg       <= err_next;
         locked_reg    <= locked_next;
         match_cnt_reg <= match_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         nibble_reg    <= nibble_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      prev_next      = prev_reg;
      consec_next    = consec_reg;
      match_next     = 1'b0;
      err_next       = 1'b0;
      locked_next    = locked_reg;
      match_cnt_next = match_cnt_reg;
      err_cnt_next   = err_cnt_reg;
      nibble_next    = nibble_reg;

      if (i_clear) begin
         // Clear wins over a simultaneous transfer: the word is dropped.
         state_next     = S_IDLE;
         consec_next    = '0;
         locked_next    = 1'b0;
         match_cnt_next = '0;
         err_cnt_next   = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (xfer) begin
                  nibble_next = s_in.data[3:0];
                  if (!word_legal) begin
                     err_next     = 1'b1;
                     err_cnt_next = sat_inc(err_cnt_reg);
                  end else begin
                     prev_next  = s_in.data[30:0];
                     state_next = S_MUL;
                  end
               end
            end
            S_MUL: state_next = S_RED;
            S_RED: state_next = S_WAIT;
            S_WAIT: begin
               if (xfer) begin
                  nibble_next = s_in.data[3:0];
                  if (s_in.data == {1'b0, expected}) begin
                     match_next     = 1'b1;
                     match_cnt_next = sat_inc(match_cnt_reg);
                     locked_next    = (consec_inc >= LOCK_V);
                     consec_next    = (consec_inc >= LOCK_V) ? LOCK_V[3:0]
                                                              : consec_inc[3:0];
                  end else begin
                     err_next     = 1'b1;
                     err_cnt_next = sat_inc(err_cnt_reg);
                     consec_next  = '0;
                     locked_next  = 1'b0;
                  end
                  // Resync on the received word so one bad word costs one
                  // error; an illegal word cannot seed, so start over.
                  if (word_legal) begin
                     prev_next  = s_in.data[30:0];
                     state_next = S_MUL;
                  end else begin
                     state_next = S_IDLE;
                  end
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

`ifdef LCG_CHK_STICKY_ERR_EN
   logic err_sticky_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_sticky_reg <= 1'b0;
      end else if (i_clear) begin
         err_sticky_reg <= 1'b0;
      end else if (err_next) begin
         err_sticky_reg <= 1'b1;
      end
   end

   assign o_err_sticky = err_sticky_reg;
`endif

   assign o_match       = match_reg;
   assign o_err         = err_reg;
   assign o_locked      = locked_reg;
   assign o_match_cnt   = match_cnt_reg;
   assign o_err_cnt     = err_cnt_reg;
   assign o_last_nibble = nibble_reg;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_lcg_stream_checker
// Directed bench for lcg_stream_checker. A second instance with CNT_W=4
// shares the same stimulus and is used for counter saturation.
// Optional build macro: LCG_CHK_STICKY_ERR_EN (adds sticky-error checks).
// -----------------------------------------------------------------------------
module tb_lcg_stream_checker;

   localparam logic [31:0] M = 32'h7FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        valid;
   logic [31:0] data;

   logic        match, err, locked;
   logic [15:0] match_cnt, err_cnt;
   logic [3:0]  nibble;
   logic        match4, err4, locked4;
   logic [3:0]  match_cnt4, err_cnt4;
   logic [3:0]  nibble4;
`ifdef LCG_CHK_STICKY_ERR_EN
   logic        sticky, sticky4;
`endif

   int errors = 0;
   int checks = 0;
   logic obs_match, obs_err;

   logic [31:0] golden [0:4];

   always #5 clk = ~clk;

   lcg_stream_checker_if bus ();
   lcg_stream_checker_if bus4 ();

   assign bus.valid  = valid;
   assign bus.data   = data;
   assign bus4.valid = valid;
   assign bus4.data  = data;

   lcg_stream_checker #(.MULT(16807), .LOCK_N(4), .CNT_W(16)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clear       (clear),
      .s_in          (bus),
      .o_match       (match),
      .o_err         (err),
      .o_locked      (locked),
      .o_match_cnt   (match_cnt),
      .o_err_cnt     (err_cnt),
      .o_last_nibble (nibble)
`ifdef LCG_CHK_STICKY_ERR_EN
      ,
      .o_err_sticky  (sticky)
`endif
   );

   lcg_stream_checker #(.MULT(16807), .LOCK_N(4), .CNT_W(4)) dut4 (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clear       (clear),
      .s_in          (bus4),
      .o_match       (match4),
      .o_err         (err4),
      .o_locked      (locked4),
      .o_match_cnt   (match_cnt4),
      .o_err_cnt     (err_cnt4),
      .o_last_nibble (nibble4)
`ifdef LCG_CHK_STICKY_ERR_EN
      ,
      .o_err_sticky  (sticky4)
`endif
   );

   // Reference next-state using a plain 64-bit modulo.
   function automatic logic [31:0] lcg_next(input logic [31:0] x);
      logic [63:0] p;
      p = (64'(x) * 64'd16807) % 64'(M);
      return p[31:0];
   endfunction

   task automatic do_reset;
      @(negedge clk);
      rst   = 1'b1;
      clear = 1'b0;
      valid = 1'b0;
      data  = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Present one word, wait (bounded) for ready, sample pulses #1 after the
   // accepting edge.
   task automatic send(input logic [31:0] w);
      int n;
      @(negedge clk);
      valid = 1'b1;
      data  = w;
      n = 0;
      while (bus.ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: ready never rose for data=%0d (waited %0d cycles, need <20)", w, n);
         valid     = 1'b0;
         obs_match = 1'b0;
         obs_err   = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         obs_match = match;
         obs_err   = err;
         valid     = 1'b0;
         $display("txn data=%0d match=%0b err=%0b match_cnt=%0d err_cnt=%0d locked=%0b",
                  w, obs_match, obs_err, match_cnt, err_cnt, locked);
      end
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({bus.ready, match, err, locked, match_cnt, err_cnt, nibble} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 4'h0}) begin
         errors++;
         $display("FAIL reset_state: ready=%0b match=%0b err=%0b locked=%0b mcnt=%0d ecnt=%0d nib=%h, need 1 0 0 0 0 0 0",
                  bus.ready, match, err, locked, match_cnt, err_cnt, nibble);
      end
`ifdef LCG_CHK_STICKY_ERR_EN
      checks++;
      if (sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset_sticky: got %0b need 0", sticky);
      end
`endif
   endtask

   task automatic test_golden;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(golden[i]);
         checks++;
         if ({obs_match, obs_err} !== {(i > 0), 1'b0}) begin
            errors++;
            $display("FAIL golden_pulse[%0d]: match=%0b err=%0b need match=%0b err=0",
                     i, obs_match, obs_err, (i > 0));
         end
         if (i == 3) begin
            checks++;
            if (locked !== 1'b0) begin
               errors++;
               $display("FAIL golden_not_locked_yet: locked=%0b need 0 after 3 matches", locked);
            end
         end
      end
      checks++;
      if ({locked, match_cnt, err_cnt, nibble} !== {1'b1, 16'd4, 16'd0, 4'hA}) begin
         errors++;
         $display("FAIL golden_final: locked=%0b mcnt=%0d ecnt=%0d nib=%h need 1 4 0 a",
                  locked, match_cnt, err_cnt, nibble);
      end
   endtask

   task automatic test_corrupt;
      do_reset();
      send(32'd1);
      send(32'd16807);
      send(32'd282475250);
      checks++;
      if ({obs_match, obs_err, locked, err_cnt} !== {1'b0, 1'b1, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL corrupt_word: match=%0b err=%0b locked=%0b ecnt=%0d need 0 1 0 1",
                  obs_match, obs_err, locked, err_cnt);
      end
      send(32'd1622650073);
      checks++;
      if ({obs_match, obs_err, err_cnt} !== {1'b0, 1'b1, 16'd2}) begin
         errors++;
         $display("FAIL corrupt_resync_err: match=%0b err=%0b ecnt=%0d need 0 1 2",
                  obs_match, obs_err, err_cnt);
      end
      send(32'd984943658);
      checks++;
      if ({obs_match, obs_err, match_cnt} !== {1'b1, 1'b0, 16'd2}) begin
         errors++;
         $display("FAIL corrupt_recover: match=%0b err=%0b mcnt=%0d need 1 0 2",
                  obs_match, obs_err, match_cnt);
      end
   endtask

   task automatic test_illegal_seed;
      logic [31:0] bad [0:2];
      bad[0] = 32'd0;
      bad[1] = 32'h7FFF_FFFF;
      bad[2] = 32'hFFFF_FFFF;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(bad[i]);
         checks++;
         if ({obs_match, obs_err, bus.ready} !== 3'b011) begin
            errors++;
            $display("FAIL illegal_seed[%0d]: match=%0b err=%0b ready=%0b need 0 1 1",
                     i, obs_match, obs_err, bus.ready);
         end
      end
      checks++;
      if ({err_cnt, match_cnt, nibble} !== {16'd3, 16'd0, 4'hF}) begin
         errors++;
         $display("FAIL illegal_counts: ecnt=%0d mcnt=%0d nib=%h need 3 0 f", err_cnt, match_cnt, nibble);
      end
`ifdef LCG_CHK_STICKY_ERR_EN
      checks++;
      if (sticky !== 1'b1) begin
         errors++;
         $display("FAIL sticky_set: got %0b need 1", sticky);
      end
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++;
      if (sticky !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear: got %0b need 0", sticky);
      end
`endif
   endtask

   task automatic test_back_to_back;
      do_reset();
      @(negedge clk);
      valid = 1'b1;
      data  = golden[0];
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_hi[%0d]: ready=%0b need 1", i, bus.ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({match, err} !== {(i > 0), 1'b0}) begin
            errors++;
            $display("FAIL b2b_pulse[%0d]: match=%0b err=%0b need match=%0b err=0", i, match, err, (i > 0));
         end
         $display("txn b2b data=%0d match=%0b err=%0b", data, match, err);
         if (i < 4) data = golden[i + 1];
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ready_lo[%0d.%0d]: ready=%0b need 0", i, k, bus.ready);
            end
         end
         @(negedge clk);
      end
      valid = 1'b0;
      checks++;
      if ({match_cnt, err_cnt} !== {16'd4, 16'd0}) begin
         errors++;
         $display("FAIL b2b_counts: mcnt=%0d ecnt=%0d need 4 0", match_cnt, err_cnt);
      end
   endtask

   task automatic test_clear;
      int n;
      do_reset();
      send(golden[0]);
      send(golden[1]);
      @(negedge clk);
      n = 0;
      while (bus.ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      valid = 1'b1;
      data  = golden[2];
      clear = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({match, err, bus.ready, locked, match_cnt, err_cnt} !==
          {1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0}) begin
         errors++;
         $display("FAIL clear_priority: match=%0b err=%0b ready=%0b locked=%0b mcnt=%0d ecnt=%0d need 0 0 1 0 0 0",
                  match, err, bus.ready, locked, match_cnt, err_cnt);
      end
      clear = 1'b0;
      valid = 1'b0;
      send(golden[2]);
      checks++;
      if ({obs_match, obs_err} !== 2'b00) begin
         errors++;
         $display("FAIL clear_reseed: match=%0b err=%0b need 0 0", obs_match, obs_err);
      end
      send(golden[3]);
      checks++;
      if ({obs_match, match_cnt} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL clear_after_match: match=%0b mcnt=%0d need 1 1", obs_match, match_cnt);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      send(golden[0]);
      send(golden[1]);
      send(golden[2]);
      // Now in S_MUL with nonzero counters and a live match pulse.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.ready, match, err, locked, match_cnt, err_cnt, nibble} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 4'h0}) begin
         errors++;
         $display("FAIL async_reset: ready=%0b match=%0b err=%0b locked=%0b mcnt=%0d ecnt=%0d nib=%h need 1 0 0 0 0 0 0",
                  bus.ready, match, err, locked, match_cnt, err_cnt, nibble);
      end
      @(negedge clk);
      rst = 1'b0;
      send(golden[1]);
      checks++;
      if ({obs_match, obs_err} !== 2'b00) begin
         errors++;
         $display("FAIL async_reset_fresh_seed: match=%0b err=%0b need 0 0", obs_match, obs_err);
      end
      send(golden[2]);
      checks++;
      if (obs_match !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_resume: match=%0b need 1", obs_match);
      end
   endtask

   task automatic test_saturation;
      logic [31:0] x;
      do_reset();
      x = 32'd1;
      for (int i = 0; i < 20; i++) begin
         send(x);
         checks++;
         if ({match4, err4} !== {(i > 0), 1'b0}) begin
            errors++;
            $display("FAIL sat_pulse[%0d]: match4=%0b err4=%0b need match4=%0b err4=0", i, match4, err4, (i > 0));
         end
         x = lcg_next(x);
      end
      checks++;
      if ({match_cnt4, err_cnt4, match_cnt} !== {4'd15, 4'd0, 16'd19}) begin
         errors++;
         $display("FAIL sat_counts: mcnt4=%0d ecnt4=%0d mcnt16=%0d need 15 0 19",
                  match_cnt4, err_cnt4, match_cnt);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      send(32'd2147483646);
      send(32'd2147466840);
      checks++;
      if ({obs_match, obs_err, nibble} !== {1'b1, 1'b0, 4'h8}) begin
         errors++;
         $display("FAIL wrap_match: match=%0b err=%0b nib=%h need 1 0 8", obs_match, obs_err, nibble);
      end
   endtask

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      valid = 1'b0;
      data  = '0;
      golden[0] = 32'd1;
      golden[1] = 32'd16807;
      golden[2] = 32'd282475249;
      golden[3] = 32'd1622650073;
      golden[4] = 32'd984943658;

      test_reset();
      test_golden();
      test_corrupt();
      test_illegal_seed();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_saturation();
      test_wrap();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (limit 200000)");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcg_stream_checker.md
Name: lcg_stream_checker

Overview:
- Receive-side counterpart of the lab1 LCG random generator: consumes a stream of 32-bit LCG states and verifies each obeys X(n+1) = 16807*X(n) mod (2^31-1).
- Acquires the seed from the first valid word, then locks after LOCK_N consecutive correct words and counts matches and errors.
- Exposes the low nibble of the last accepted word, so the board shows the same digit as the generator's o_random_out.

Parameters:
- MULT, 16807, LCG multiplier (must be < 2^15).
- LOCK_N, 4, consecutive matches required to assert o_locked (1..15).
- CNT_W, 16, width of the match and error counters (saturating).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_clear  in  1  synchronous soft clear: counters to 0, state to S_IDLE
- i_valid  in  1  input word valid
- o_ready  out  1  checker can accept; a transfer occurs when i_valid && o_ready
- i_data  in  32  LCG state word
- o_match  out  1  one-cycle pulse: accepted word equalled the expected value
- o_err  out  1  one-cycle pulse: accepted word mismatched or was an illegal seed
- o_locked  out  1  LOCK_N consecutive matches seen since the last error or clear
- o_match_cnt  out  CNT_W  total matches, saturating
- o_err_cnt  out  CNT_W  total errors, saturating
- o_last_nibble  out  4  i_data[3:0] of the last accepted word

Behaviour:
- Reset (async, i_rst=1):
  - state=S_IDLE, o_ready=1.
  - o_match, o_err, o_locked = 0; both counters = 0; o_last_nibble = 0.
  - prev, expected, product and consecutive-match registers = 0.
- Constant M = 2^31-1. Legal word: 1 <= word <= M-1.
- States:
  - S_IDLE (ready=1): on transfer, if the word is illegal, pulse o_err, increment err_cnt and stay. Otherwise prev<=word and go to S_MUL.
  - S_MUL (ready=0): product <= prev*MULT, 46-bit unsigned. Go to S_RED.
  - S_RED (ready=0): s = product[30:0] + product[45:31] (32-bit). expected <= (s >= M) ? s-M : s. Go to S_WAIT.
  - S_WAIT (ready=1): on transfer, compare the word with expected.
    - Match: pulse o_match, increment match_cnt, consec <= min(consec+1, LOCK_N), o_locked <= (consec+1 >= LOCK_N).
    - Mismatch: pulse o_err, increment err_cnt, consec <= 0, o_locked <= 0.
    - Either case, legal word: prev<=word and go to S_MUL (resync on the received word). Illegal word: go to S_IDLE.
- Timing:
  - o_match and o_err are registered; they are high for exactly the cycle after the transfer.
  - o_last_nibble updates in that same cycle.
  - After any accept, o_ready is low for exactly 2 cycles. Peak throughput is 1 word per 3 cycles.
- Counters saturate at all-ones and never wrap.
- i_clear has priority over a simultaneous transfer; the word is dropped and no pulse is generated.
- i_valid is ignored while o_ready=0. Senders hold the word until a transfer occurs.
- An i_rst assertion mid-computation abandons the computation immediately; the next word is treated as a fresh seed.

Optional Feature:
- Macro LCG_CHK_STICKY_ERR_EN.
- Defined: adds output o_err_sticky (1 bit). It is set on any o_err pulse and cleared only by i_rst or i_clear. The reset value is 0.
- Undefined: the port is absent and all other behaviour is unchanged.

Decomposition:
- Shared package lcg_pkg holds:
  - LCG_MOD = 32'h7FFF_FFFF and LCG_MULT_DEFAULT = 16807;
  - the state enum typedef {S_IDLE, S_MUL, S_RED, S_WAIT};
  - a function lcg_legal(word).
- Sub-module lcg_modmul: a registered 2-stage multiply/reduce (S_MUL/S_RED datapath) with ports i_clk, i_rst, i_x[30:0], o_y[30:0]. The generator can reuse it later in place of its `%` operator.

Test Plan:
- Golden stream: send 1, 16807, 282475249, 1622650073, 984943658 -> 4 o_match pulses, o_match_cnt=4, o_locked=1 after the 5th word, o_err_cnt=0, o_last_nibble=4'hA.
- Corrupt word: after seed 1 and 16807, send 282475250 -> o_err pulse, o_locked=0, err_cnt=1. Then send 1622650073 -> o_err, since the checker resynced and expects next(282475250). Then send next(1622650073)=984943658 -> o_match.
- Illegal seed: in S_IDLE send 0, then 32'h7FFF_FFFF, then 32'hFFFF_FFFF -> 3 o_err pulses, err_cnt=3, state stays S_IDLE, o_ready stays high.
- Handshake and throughput: hold i_valid high continuously with the golden stream -> o_ready pattern 1,0,0 repeating; no word is lost or duplicated; match_cnt equals words-1.
- Clear and reset precedence:
  - i_clear asserted in the same cycle as a transfer -> no pulse, counters=0, S_IDLE.
  - Async i_rst pulse during S_MUL -> all outputs return to their reset values within the same cycle.
- Saturation and wrap-around, with CNT_W=4: 20 golden words -> match_cnt holds at 15. A wrap-around case, seed 2147483646 (M-1), expects 2147466840 -> o_match.
